// File: rtl/mdu_hilo_if.sv
// Request/result bundle between the EX stage and the HI/LO multiply/divide unit.
// The master drives the request fields; the slave (mdu_hilo) returns status and HI/LO.
interface mdu_hilo_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, hi, lo);
endinterface

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO plus MTHI/MTLO writes.
// Define MDU_FAST_MUL_EN for single-cycle multiplies; divides always stay iterative.
module mdu_hilo #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  mdu_hilo_if.slave    bus
);

`ifdef MDU_FAST_MUL_EN
  localparam bit FAST_MUL = 1'b1;
`else
  localparam bit FAST_MUL = 1'b0;
`endif

  localparam int CW = $clog2(WIDTH);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_e;

  state_e             r_state, w_state_nxt;
  logic               w_busy, w_accept;
  logic               w_is_mul, w_is_div, w_signed;
  logic               w_a_neg, w_b_neg;
  logic [WIDTH-1:0]   w_a_mag, w_b_mag;

  logic [WIDTH-1:0]   r_hi, r_lo;
  logic               r_done;
  logic [WIDTH-1:0]   r_acc_hi, r_acc_lo, r_opnd, r_a_raw;
  logic [CW-1:0]      r_cnt;
  logic               r_is_div, r_neg_res, r_neg_rem, r_div0;

  logic [WIDTH:0]     w_mul_sum, w_rem_sh, w_diff;
  logic               w_qbit;
  logic [WIDTH-1:0]   w_rem_nxt;
  logic [2*WIDTH-1:0] w_prod_fix, w_ext_a, w_ext_b, w_fast_prod;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix;

  // Request decode and operand magnitudes; MULT/DIV (op[0]==0) are the signed forms.
  assign w_is_mul = (bus.op == OP_MULT) || (bus.op == OP_MULTU);
  assign w_is_div = (bus.op == OP_DIV)  || (bus.op == OP_DIVU);
  assign w_signed = ~bus.op[0];
  assign w_a_neg  = w_signed & bus.a[WIDTH-1];
  assign w_b_neg  = w_signed & bus.b[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -bus.a : bus.a;
  assign w_b_mag  = w_b_neg ? -bus.b : bus.b;
  assign w_accept = bus.start && (r_state == S_IDLE);

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic
  // NOTE: the default assignment up front keeps this block free of inferred latches.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: if (w_accept) begin
                if (w_is_mul && !FAST_MUL) w_state_nxt = S_MUL;
                else if (w_is_div)         w_state_nxt = S_DIV;
              end
      S_MUL,
      S_DIV:  if (r_cnt == '0) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    w_busy = (r_state != S_IDLE);
  end

  // One shift-add step: product high half grows while the multiplier shifts out of acc_lo.
  assign w_mul_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opnd} : '0);

  // One restoring-divide step: shift in the next dividend bit, subtract if it fits.
  assign w_rem_sh  = {r_acc_hi, r_acc_lo[WIDTH-1]};
  assign w_diff    = w_rem_sh - {1'b0, r_opnd};
  assign w_qbit    = ~w_diff[WIDTH];
  assign w_rem_nxt = w_qbit ? w_diff[WIDTH-1:0] : w_rem_sh[WIDTH-1:0];

  assign w_prod_fix = r_neg_res ? -{r_acc_hi, r_acc_lo} : {r_acc_hi, r_acc_lo};
  assign w_quo_fix  = r_neg_res ? -r_acc_lo : r_acc_lo;
  assign w_rem_fix  = r_neg_rem ? -r_acc_hi : r_acc_hi;

  // Sign-extended to 2*WIDTH, the low half of the product is correct for both signednesses.
  assign w_ext_a     = {{WIDTH{w_a_neg}}, bus.a};
  assign w_ext_b     = {{WIDTH{w_b_neg}}, bus.b};
  assign w_fast_prod = w_ext_a * w_ext_b;

  // Working datapath
  // NOTE: these registers are loaded on every accept before use, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_acc_hi  <= '0;
      r_acc_lo  <= w_is_mul ? w_b_mag : w_a_mag;
      r_opnd    <= w_is_mul ? w_a_mag : w_b_mag;
      r_cnt     <= CW'(WIDTH - 1);
      r_is_div  <= w_is_div;
      r_neg_res <= w_a_neg ^ w_b_neg;
      r_neg_rem <= w_a_neg;
      r_div0    <= (bus.b == '0);
      r_a_raw   <= bus.a;
    end else if (r_state == S_MUL) begin
      {r_acc_hi, r_acc_lo} <= {w_mul_sum, r_acc_lo[WIDTH-1:1]};
      r_cnt                <= r_cnt - CW'(1);
    end else if (r_state == S_DIV) begin
      r_acc_hi <= w_rem_nxt;
      r_acc_lo <= {r_acc_lo[WIDTH-2:0], w_qbit};
      r_cnt    <= r_cnt - CW'(1);
    end
  end

  // Architectural HI/LO: only FIX, MTHI/MTLO and a fast multiply may write them.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (r_state == S_FIX) begin
        r_done <= 1'b1;
        if (!r_is_div) begin
          {r_hi, r_lo} <= w_prod_fix;
        end else if (r_div0) begin
          r_hi <= r_a_raw;
          r_lo <= '1;
        end else begin
          r_hi <= w_rem_fix;
          r_lo <= w_quo_fix;
        end
      end else if (w_accept) begin
        if (bus.op == OP_MTHI)            r_hi <= bus.a;
        else if (bus.op == OP_MTLO)       r_lo <= bus.a;
        else if (FAST_MUL && w_is_mul) begin
          {r_hi, r_lo} <= w_fast_prod;
          r_done       <= 1'b1;
        end
      end
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed self-checking bench for mdu_hilo: MULT/DIV results, latency, HI/LO hold,
// start masking, MTHI/MTLO, reserved ops, mid-operation reset and back-to-back issue.
module tb_mdu_hilo;

  localparam int W = 32;
`ifdef MDU_FAST_MUL_EN
  localparam int   MUL_LAT  = 0;
  localparam logic MUL_BUSY = 1'b0;
  localparam logic [2:0] RST_OP = 3'd2;
`else
  localparam int   MUL_LAT  = W + 1;
  localparam logic MUL_BUSY = 1'b1;
  localparam logic [2:0] RST_OP = 3'd0;
`endif
  localparam int DIV_LAT = W + 1;

  logic clk;
  logic rst;
  int   errors = 0;
  int   checks = 0;

  mdu_hilo_if #(.WIDTH(W)) bus ();

  mdu_hilo #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issue one request and follow it to its done pulse (lat=-1 if it never comes).
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic busy_acc, output logic held);
    logic [W-1:0] hi0, lo0;
    @(negedge clk);
    hi0 = bus.hi;
    lo0 = bus.lo;
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.op    = 3'd7;
    bus.a     = 32'hA5A5_5A5A;
    bus.b     = 32'h5A5A_A5A5;
    busy_acc  = bus.busy;
    held      = 1'b1;
    lat       = -1;
    if (bus.done) lat = 0;
    else begin
      for (int n = 1; n <= 100; n++) begin
        if (bus.hi !== hi0 || bus.lo !== lo0 || bus.busy !== 1'b1) held = 1'b0;
        @(posedge clk); #1;
        if (bus.done) begin
          lat = n;
          break;
        end
      end
    end
  endtask

  task automatic test_arith_op(input string name, input logic [2:0] op,
                               input logic [W-1:0] a, input logic [W-1:0] b,
                               input logic [2*W-1:0] exp_hilo, input int exp_lat,
                               input logic exp_busy);
    int   lat;
    logic busy_acc, held;
    run_op(op, a, b, lat, busy_acc, held);
    checks++;
    if (lat !== exp_lat) begin
      errors++;
      $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
    end
    checks++;
    if (busy_acc !== exp_busy) begin
      errors++;
      $display("FAIL %s busy_after_accept: got %b expected %b", name, busy_acc, exp_busy);
    end
    checks++;
    if (held !== 1'b1) begin
      errors++;
      $display("FAIL %s hold_during_busy: got %b expected 1", name, held);
    end
    checks++;
    if ({bus.hi, bus.lo} !== exp_hilo) begin
      errors++;
      $display("FAIL %s hilo: got %h_%h expected %h", name, bus.hi, bus.lo, exp_hilo);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s busy_at_done: got %b expected 0", name, bus.busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.op = 3'd0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.hi, bus.lo} !== 64'h0) begin
      errors++;
      $display("FAIL reset_hilo: got %h_%h expected 0", bus.hi, bus.lo);
    end
    checks++;
    if ({bus.busy, bus.done} !== 2'b00) begin
      errors++;
      $display("FAIL reset_busy_done: got %b expected 00", {bus.busy, bus.done});
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_multiply();
    test_arith_op("mult_neg3x7", 3'd0, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, MUL_LAT, MUL_BUSY);
    @(posedge clk); #1;
    checks++;
    if (bus.done !== 1'b0) begin
      errors++;
      $display("FAIL mult_done_width: got %b expected 0", bus.done);
    end
    test_arith_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, MUL_LAT, MUL_BUSY);
    test_arith_op("mult_m1xm1", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001, MUL_LAT, MUL_BUSY);
    test_arith_op("multu_2p16", 3'd1, 32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, MUL_LAT, MUL_BUSY);
    test_arith_op("mult_6x7", 3'd0, 32'd6, 32'd7, 64'd42, MUL_LAT, MUL_BUSY);
  endtask

  task automatic test_divide();
    test_arith_op("div_m7_2", 3'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, DIV_LAT, 1'b1);
    test_arith_op("divu_7_2", 3'd3, 32'd7, 32'd2, 64'h0000_0001_0000_0003, DIV_LAT, 1'b1);
    test_arith_op("div_7_m2", 3'd2, 32'd7, 32'hFFFF_FFFE, 64'h0000_0001_FFFF_FFFD, DIV_LAT, 1'b1);
    test_arith_op("divu_max_2", 3'd3, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_7FFF_FFFF, DIV_LAT, 1'b1);
    test_arith_op("div_by_zero", 3'd2, 32'd5, 32'd0, 64'h0000_0005_FFFF_FFFF, DIV_LAT, 1'b1);
    test_arith_op("div_overflow", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, DIV_LAT, 1'b1);
  endtask

  task automatic test_start_ignored();
    int lat;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 3'd2;
    bus.a = 32'd100;
    bus.b = 32'd7;
    lat = -1;
    for (int n = 1; n <= 100; n++) begin
      @(posedge clk); #1;
      if (bus.done) begin
        lat = n - 1;
        break;
      end
      @(negedge clk);
      bus.op = 3'(n % 6);
      bus.a = $urandom;
      bus.b = $urandom;
    end
    bus.start = 1'b0;
    checks++;
    if (lat !== DIV_LAT) begin
      errors++;
      $display("FAIL ignore_start_latency: got %0d expected %0d", lat, DIV_LAT);
    end
    checks++;
    if ({bus.hi, bus.lo} !== 64'h0000_0002_0000_000E) begin
      errors++;
      $display("FAIL ignore_start_hilo: got %h_%h expected 00000002_0000000e", bus.hi, bus.lo);
    end
  endtask

  task automatic test_move_to();
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 3'd4;
    bus.a = 32'h0000_1234;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if ({bus.hi, bus.lo, bus.busy, bus.done} !== {32'h0000_1234, 32'h0000_000E, 2'b00}) begin
      errors++;
      $display("FAIL mthi: got hi=%h lo=%h busy=%b done=%b expected hi=00001234 lo=0000000e busy=0 done=0",
               bus.hi, bus.lo, bus.busy, bus.done);
    end
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = 3'd5;
    bus.a = 32'h0000_5678;
    @(posedge clk); #1;
    bus.start = 1'b0;
    checks++;
    if ({bus.hi, bus.lo, bus.busy, bus.done} !== {32'h0000_1234, 32'h0000_5678, 2'b00}) begin
      errors++;
      $display("FAIL mtlo: got hi=%h lo=%h busy=%b done=%b expected hi=00001234 lo=00005678 busy=0 done=0",
               bus.hi, bus.lo, bus.busy, bus.done);
    end
  endtask

  task automatic test_reserved();
    for (int k = 6; k <= 7; k++) begin
      @(negedge clk);
      bus.start = 1'b1;
      bus.op = 3'(k);
      bus.a = 32'hDEAD_BEEF;
      bus.b = 32'h1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      @(posedge clk); #1;
      checks++;
      if ({bus.hi, bus.lo, bus.busy, bus.done} !== {32'h0000_1234, 32'h0000_5678, 2'b00}) begin
        errors++;
        $display("FAIL reserved_op%0d: got hi=%h lo=%h busy=%b done=%b expected no change, idle",
                 k, bus.hi, bus.lo, bus.busy, bus.done);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    logic saw_done;
    @(negedge clk);
    bus.start = 1'b1;
    bus.op = RST_OP;
    bus.a = 32'd3;
    bus.b = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({bus.hi, bus.lo, bus.busy, bus.done} !== {64'h0, 2'b00}) begin
      errors++;
      $display("FAIL reset_mid_op: got hi=%h lo=%h busy=%b done=%b expected all 0",
               bus.hi, bus.lo, bus.busy, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy || bus.hi != '0 || bus.lo != '0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort: got activity=%b expected 0 after reset", saw_done);
    end
  endtask

  task automatic test_back_to_back();
    test_arith_op("b2b_divu_7_2", 3'd3, 32'd7, 32'd2, 64'h0000_0001_0000_0003, DIV_LAT, 1'b1);
    test_arith_op("b2b_div_9_4", 3'd2, 32'd9, 32'd4, 64'h0000_0001_0000_0002, DIV_LAT, 1'b1);
    test_arith_op("b2b_multu_6x7", 3'd1, 32'd6, 32'd7, 64'd42, MUL_LAT, MUL_BUSY);
  endtask

  initial begin
    test_reset();
    test_multiply();
    test_divide();
    test_start_ignored();
    test_move_to();
    test_reserved();
    test_reset_mid_op();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
